// File: rtl/ft245_sync_to_axis.sv
// FT245 synchronous FIFO bridge: FT245 reads become an AXI-Stream master,
// and an AXI-Stream slave feeds FT245 writes. All logic runs on the FT245 data clock.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | bus released, waiting for read data or write data
// WRITE    | bridge drives the bus; one word per edge while txen=0 and tvalid=1
// READ_OE  | output enable asserted for one cycle so the FT245 can turn the bus
// READ     | FT245 drives the bus; one word per edge while rxfn=0 and tready=1

module ft245_sync_to_axis #(
    parameter int bus_width = 4
) (
    input  logic                   ft245_dclk,
    input  logic                   rstn,

    inout  wire  [bus_width-1:0]   ft245_ben,
    inout  wire  [bus_width*8-1:0] ft245_data,
    output logic                   ft245_rdn,
    output logic                   ft245_wrn,
    output logic                   ft245_siwun,
    input  logic                   ft245_txen,
    input  logic                   ft245_rxfn,
    output logic                   ft245_oen,
    output logic                   ft245_rstn,
    output logic                   ft245_wakeupn,

    output logic [bus_width*8-1:0] m_axis_tdata,
    output logic [bus_width-1:0]   m_axis_tkeep,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,

    input  logic [bus_width*8-1:0] s_axis_tdata,
    input  logic [bus_width-1:0]   s_axis_tkeep,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_READ_OE = 2'd2,
        ST_READ    = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   bus_drive;
    logic   rd_go;
    logic   wr_go;

    assign rd_go = ~ft245_rxfn & m_axis_tready;
    assign wr_go = ~ft245_txen & s_axis_tvalid;

    always_ff @(posedge ft245_dclk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are combinational so a word moves on the very edge where both sides agree;
    // the async reset of the state register kills any strobe immediately.
    always_comb begin
        state_nxt     = state;
        bus_drive     = 1'b0;
        ft245_oen     = 1'b1;
        ft245_rdn     = 1'b1;
        ft245_wrn     = 1'b1;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rd_go) begin
                    state_nxt = ST_READ_OE;
                end else if (wr_go) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                bus_drive     = 1'b1;
                s_axis_tready = ~ft245_txen;
                ft245_wrn     = ~wr_go;
                if (!wr_go) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_READ_OE: begin
                ft245_oen = 1'b0;
                state_nxt = ST_READ;
            end
            ST_READ: begin
                ft245_oen     = 1'b0;
                ft245_rdn     = ~rd_go;
                m_axis_tvalid = rd_go;
                if (!rd_go) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ft245_data = bus_drive ? s_axis_tdata : 'z;
    assign ft245_ben  = bus_drive ? s_axis_tkeep : 'z;

    assign m_axis_tdata = ft245_data;
    assign m_axis_tkeep = ft245_ben;

    assign ft245_siwun   = 1'b1;
    assign ft245_wakeupn = 1'b1;
    assign ft245_rstn    = rstn;

endmodule

// File: tb/tb_ft245_sync_to_axis.sv
// Bench for ft245_sync_to_axis (bus_width=1): random write bursts, an FT245 read model,
// read/write arbitration and mid-burst reset, checked by scoreboards.
`timescale 1ns/1ps

module tb_ft245_sync_to_axis;

    localparam int BW = 1;
    localparam int DW = 8;

    logic          tb_data_clk = 1'b0;
    logic          rstn;
    wire  [BW-1:0] ft_ben;
    wire  [DW-1:0] ft_data;
    logic          ft_rdn, ft_wrn, ft_siwun, ft_txen, ft_rxfn, ft_oen, ft_rstn, ft_wakeupn;
    logic [DW-1:0] m_tdata;
    logic [BW-1:0] m_tkeep;
    logic          m_tvalid, m_tready;
    logic [DW-1:0] s_tdata;
    logic [BW-1:0] s_tkeep;
    logic          s_tvalid, s_tready;

    ft245_sync_to_axis #(.bus_width(BW)) dut (
        .ft245_dclk    (tb_data_clk),
        .rstn          (rstn),
        .ft245_ben     (ft_ben),
        .ft245_data    (ft_data),
        .ft245_rdn     (ft_rdn),
        .ft245_wrn     (ft_wrn),
        .ft245_siwun   (ft_siwun),
        .ft245_txen    (ft_txen),
        .ft245_rxfn    (ft_rxfn),
        .ft245_oen     (ft_oen),
        .ft245_rstn    (ft_rstn),
        .ft245_wakeupn (ft_wakeupn),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready)
    );

    // Rising edges at 7, 17, 27 ... so the scheduled times below fall between edges.
    initial begin
        #2;
        forever #5 tb_data_clk = ~tb_data_clk;
    end

    // Pull-ups make a released bus read as all ones. Write data keeps tkeep = ~tdata[0],
    // so a driven bus can never look like the released pattern on both data and ben.
    for (genvar i = 0; i < DW; i++) begin : g_pu_data
        pullup (ft_data[i]);
    end
    for (genvar i = 0; i < BW; i++) begin : g_pu_ben
        pullup (ft_ben[i]);
    end

    logic [8:0] rd_word;
    assign ft_data = (!ft_oen && !ft_rxfn) ? rd_word[7:0] : 'z;
    assign ft_ben  = (!ft_oen && !ft_rxfn) ? rd_word[8]   : 'z;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [8:0]  sb_wr[$];
    logic [8:0]  sb_rd[$];
    logic [8:0]  rd_src[$];
    int unsigned wr_issued = 0, wr_seen = 0, rd_loaded = 0, rd_seen = 0;
    logic        wr_rand_en = 1'b0;
    logic        rd_rand_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge tb_data_clk);
        #3;
    endtask

    task automatic at_time(input longint t);
        if (t > $time) #(t - $time);
    endtask

    task automatic load_rd(input logic [8:0] w);
        rd_src.push_back(w);
        sb_rd.push_back(w);
        rd_loaded++;
    endtask

    task automatic chk_hiz(input string name);
        chk({name, "_data_hiz"}, 32'(ft_data), 32'hFF);
        chk({name, "_ben_hiz"}, 32'(ft_ben), 32'h1);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_wrn"}, 32'(ft_wrn), 32'd1);
        chk({name, "_rdn"}, 32'(ft_rdn), 32'd1);
        chk({name, "_oen"}, 32'(ft_oen), 32'd1);
        chk({name, "_s_tready"}, 32'(s_tready), 32'd0);
        chk({name, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({name, "_ft_rstn"}, 32'(ft_rstn), 32'd0);
        chk_hiz(name);
    endtask

    // Write stimulus: data counts up from 65 on every accepted word; expected words are queued.
    initial begin : wr_driver
        logic       hs;
        logic [7:0] exp_d;
        forever begin
            @(negedge tb_data_clk);
            hs = s_tvalid && s_tready;
            if (hs) begin
                exp_d = 8'(65 + wr_issued);
                sb_wr.push_back({~exp_d[0], exp_d});
                wr_issued++;
            end
            @(posedge tb_data_clk);
            #1;
            if (hs) begin
                s_tdata = 8'(65 + wr_issued);
                s_tkeep = ~s_tdata[0];
            end
            if (wr_rand_en) s_tvalid = 1'($urandom_range(0, 1));
        end
    end

    // FT245 side of writes: every edge with wrn=0 and txen=0 stores one word.
    initial begin : wr_mon
        logic [8:0] exp_w;
        forever begin
            @(negedge tb_data_clk);
            #1;
            if (!ft_wrn && !ft_txen) begin
                wr_seen++;
                chk("wr_word_expected", 32'(sb_wr.size() != 0), 32'd1);
                if (sb_wr.size() != 0) begin
                    exp_w = sb_wr.pop_front();
                    chk("wr_bus_word", 32'({ft_ben, ft_data}), 32'(exp_w));
                end
            end
        end
    end

    // FT245 read model: presents queued words while oen is low, advances on each rdn=0 edge.
    initial begin : ft_rd_model
        logic       take;
        logic [8:0] dropped;
        ft_rxfn = 1'b1;
        rd_word = 9'h0;
        forever begin
            @(negedge tb_data_clk);
            take = !ft_rdn && !ft_rxfn;
            @(posedge tb_data_clk);
            #1;
            if (take && rd_src.size() != 0) dropped = rd_src.pop_front();
            #1;
            ft_rxfn = (rd_src.size() == 0);
            rd_word = (rd_src.size() != 0) ? rd_src[0] : 9'h0;
        end
    end

    initial begin : rd_ready_drv
        forever begin
            @(posedge tb_data_clk);
            #1;
            if (rd_rand_en) m_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : rd_mon
        logic [8:0] exp_r;
        forever begin
            @(negedge tb_data_clk);
            #1;
            if (m_tvalid && m_tready) begin
                rd_seen++;
                chk("rd_word_expected", 32'(sb_rd.size() != 0), 32'd1);
                if (sb_rd.size() != 0) begin
                    exp_r = sb_rd.pop_front();
                    chk("rd_axis_word", 32'({m_tkeep, m_tdata}), 32'(exp_r));
                end
            end
        end
    end

    // Bus ownership: read and write cycles never overlap or touch without an idle cycle between.
    initial begin : dir_mon
        logic rd_prev, wr_prev, rd_now, wr_now;
        rd_prev = 1'b0;
        wr_prev = 1'b0;
        forever begin
            @(negedge tb_data_clk);
            #1;
            rd_now = !ft_oen;
            wr_now = !ft_wrn || s_tready;
            if (rstn) begin
                chk("bus_turnaround",
                    32'({rd_now && wr_prev, wr_now && rd_prev, rd_now && wr_now,
                         m_tvalid && ft_oen, s_tready && !ft_oen}), 32'd0);
            end
            rd_prev = rd_now;
            wr_prev = wr_now;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: run did not complete (t=%0t)", $time);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        rstn     = 1'b0;
        ft_txen  = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        s_tdata  = 8'd65;
        s_tkeep  = 1'b0;

        at_time(100);
        chk_reset("rst_early");
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        at_time(300);
        chk_reset("rst_late");
        chk("siwun", 32'(ft_siwun), 32'd1);
        chk("wakeupn", 32'(ft_wakeupn), 32'd1);

        at_time(500);
        rstn       = 1'b1;
        ft_txen    = 1'b0;
        wr_rand_en = 1'b1;
        #1;
        chk("post_rst_wrn", 32'(ft_wrn), 32'd1);
        chk("post_rst_tready", 32'(s_tready), 32'd0);
        chk("ft_rstn_run", 32'(ft_rstn), 32'd1);

        // Hold a burst, then reset in the middle of it.
        at_time(2950);
        wr_rand_en = 1'b0;
        s_tvalid   = 1'b1;
        at_time(3001);
        chk("burst_wrn", 32'(ft_wrn), 32'd0);
        chk("burst_tready", 32'(s_tready), 32'd1);
        at_time(3003);
        rstn = 1'b0;
        #1;
        chk_reset("mid_burst_rst");
        at_time(3023);
        rstn = 1'b1;
        #1;
        chk("rst_release_wrn", 32'(ft_wrn), 32'd1);
        at_time(3030);
        wr_rand_en = 1'b1;

        // Burst running when the FT245 stops accepting data.
        at_time(5400);
        wr_rand_en = 1'b0;
        s_tvalid   = 1'b1;
        at_time(5499);
        chk("pre_txen_wrn", 32'(ft_wrn), 32'd0);
        chk("pre_txen_tready", 32'(s_tready), 32'd1);
        at_time(5500);
        ft_txen = 1'b1;
        #1;
        chk("txen_rise_tready", 32'(s_tready), 32'd0);
        chk("txen_rise_wrn", 32'(ft_wrn), 32'd1);
        at_time(5531);
        chk("after_txen_oen", 32'(ft_oen), 32'd1);
        chk_hiz("after_txen");
        for (int i = 0; i < 5; i++) begin
            @(negedge tb_data_clk);
            #1;
            chk("after_txen_no_write", 32'(ft_wrn), 32'd1);
        end
        s_tvalid = 1'b0;

        // Directed read of three words.
        tick();
        m_tready = 1'b1;
        load_rd(9'h111);
        load_rd(9'h122);
        load_rd(9'h133);
        for (n = 0; n < 50; n++) begin
            @(negedge tb_data_clk);
            #1;
            if (!ft_oen) break;
        end
        chk("oe_wait_in_time", 32'(n < 50), 32'd1);
        chk("oe_only_rdn", 32'(ft_rdn), 32'd1);
        chk("oe_only_tvalid", 32'(m_tvalid), 32'd0);
        @(negedge tb_data_clk);
        #1;
        chk("read_rdn", 32'(ft_rdn), 32'd0);
        chk("read_tvalid", 32'(m_tvalid), 32'd1);
        chk("read_first_data", 32'(m_tdata), 32'h11);
        for (n = 0; n < 100; n++) begin
            @(negedge tb_data_clk);
            #1;
            if (sb_rd.size() == 0 && ft_oen) break;
        end
        chk("read_drain_in_time", 32'(n < 100), 32'd1);

        // Random read words with a stalling consumer.
        tick();
        rd_rand_en = 1'b1;
        for (int i = 0; i < 24; i++) load_rd({1'($urandom_range(0, 1)), 8'($urandom)});
        for (n = 0; n < 600; n++) begin
            @(negedge tb_data_clk);
            #1;
            if (sb_rd.size() == 0 && ft_oen) break;
        end
        chk("rand_read_drain_in_time", 32'(n < 600), 32'd1);
        tick();
        rd_rand_en = 1'b0;
        m_tready   = 1'b0;

        // Read and write both pending in IDLE: read wins, write follows after an idle gap.
        tick();
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) load_rd({1'b1, 8'($urandom)});
        tick();
        ft_txen  = 1'b0;
        s_tvalid = 1'b1;
        for (n = 0; n < 20; n++) begin
            @(negedge tb_data_clk);
            #1;
            if (!ft_oen || !ft_wrn) break;
        end
        chk("arb_activity_in_time", 32'(n < 20), 32'd1);
        chk("arb_read_first_oen", 32'(ft_oen), 32'd0);
        chk("arb_read_first_wrn", 32'(ft_wrn), 32'd1);
        for (n = 0; n < 50; n++) begin
            @(negedge tb_data_clk);
            #1;
            if (ft_oen) break;
        end
        chk("arb_read_end_in_time", 32'(n < 50), 32'd1);
        chk("arb_gap_wrn", 32'(ft_wrn), 32'd1);
        chk("arb_gap_tready", 32'(s_tready), 32'd0);
        chk_hiz("arb_gap");
        for (n = 0; n < 20; n++) begin
            @(negedge tb_data_clk);
            #1;
            if (!ft_wrn) break;
        end
        chk("arb_write_follows", 32'(n < 20), 32'd1);
        repeat (8) tick();
        ft_txen  = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        repeat (5) tick();

        chk("wr_sb_empty", 32'(sb_wr.size()), 32'd0);
        chk("rd_sb_empty", 32'(sb_rd.size()), 32'd0);
        chk("wr_word_count", 32'(wr_seen), 32'(wr_issued));
        chk("rd_word_count", 32'(rd_seen), 32'(rd_loaded));
        chk("wr_burst_nonempty", 32'(wr_issued > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ft245_sync_to_axis.md
FT245_SYNC_TO_AXIS -- requirements
Module: ft245_sync_to_axis

Interface
REQ-001 SHALL have parameter bus_width, default 4, giving the number of bytes per FT245 bus word; D = bus_width*8.
REQ-002 SHALL have one clock and an asynchronous, active-low reset:
- ft245_dclk  in  1  FT245 synchronous data clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
REQ-003 SHALL have these FT245 ports:
- ft245_ben  inout  bus_width  byte enables.
- ft245_data  inout  D  bidirectional data.
- ft245_rdn  out  1  read strobe, active low.
- ft245_wrn  out  1  write strobe, active low.
- ft245_siwun  out  1  send-immediate, active low.
- ft245_txen  in  1  low = FT245 can accept write data.
- ft245_rxfn  in  1  low = FT245 has read data.
- ft245_oen  out  1  output enable, active low.
- ft245_rstn  out  1  FT245 reset, active low.
- ft245_wakeupn  out  1  wakeup, active low.
REQ-004 SHALL have these AXIS ports:
- m_axis_tdata/tkeep/tvalid  out  D/bus_width/1  and m_axis_tready  in  1: read stream.
- s_axis_tdata/tkeep/tvalid  in  D/bus_width/1  and s_axis_tready  out  1: write stream.

Function
REQ-005 SHALL implement a registered state machine: IDLE, WRITE, READ_OE, READ.
REQ-006 IDLE: ft245_data and ft245_ben SHALL be high-Z; oen, rdn and wrn SHALL be 1; s_axis_tready and m_axis_tvalid SHALL be 0.
REQ-007 IDLE -> READ_OE when ft245_rxfn=0 and m_axis_tready=1 (read has priority).
REQ-008 Otherwise, IDLE -> WRITE when ft245_txen=0 and s_axis_tvalid=1.
REQ-009 WRITE outputs:
- ft245_data = s_axis_tdata and ft245_ben = s_axis_tkeep, driven.
- s_axis_tready = ~ft245_txen.
- ft245_wrn = ~(s_axis_tvalid & ~ft245_txen), combinational.
REQ-010 Write transfer: exactly one word SHALL be written per rising edge with s_axis_tvalid=1 and s_axis_tready=1; no word dropped or duplicated.
REQ-011 WRITE -> IDLE at the first edge where ft245_txen=1 or s_axis_tvalid=0.
REQ-012 READ_OE lasts exactly one cycle:
- ft245_oen = 0; rdn = 1; bus high-Z.
- Then -> READ.
REQ-013 READ outputs:
- oen = 0; bus high-Z.
- ft245_rdn = ~(~ft245_rxfn & m_axis_tready).
- m_axis_tdata = ft245_data; m_axis_tkeep = ft245_ben.
- m_axis_tvalid = ~ft245_rxfn & ~ft245_rdn.
REQ-014 Read transfer: one word per edge with m_axis_tvalid & m_axis_tready.
REQ-015 READ -> IDLE at the first edge where ft245_rxfn=1 or m_axis_tready=0.
REQ-016 Every change of bus direction SHALL pass through at least one IDLE cycle; the DUT SHALL never drive ft245_data while ft245_oen=0.
REQ-017 In WRITE, ft245_rxfn going low SHALL NOT abort a pending write; the read starts after the return to IDLE.
REQ-018 Constant outputs:
- ft245_siwun = 1.
- ft245_wakeupn = 1.
- ft245_rstn = rstn.
REQ-019 m_axis_tvalid SHALL be 0 in every state except READ; s_axis_tready SHALL be 0 in every state except WRITE.

Reset
REQ-020 While rstn=0 the DUT SHALL hold:
- state = IDLE.
- oen = rdn = wrn = 1.
- ft245_data and ft245_ben high-Z.
- s_axis_tready = 0; m_axis_tvalid = 0.
- ft245_rstn = 0.
REQ-021 Reset asserted mid-transfer SHALL abort the transfer immediately; no partial strobe SHALL be produced.
REQ-022 After rstn rises, the first transfer SHALL start no earlier than the first rising edge of ft245_dclk.

Verification
REQ-023 Reset held for 500 ns with txen=1 -> during reset: wrn=1, rdn=1, oen=1, bus high-Z, s_axis_tready=0, ft245_rstn=0.
REQ-024 bus_width=1; txen=0 from 500 ns to 5500 ns; random s_axis_tvalid; tdata counts from 8'd65 on each handshake -> FT bus carries 65, 66, 67, ... in order, one byte per edge with wrn=0 and txen=0.
REQ-025 txen rises at 5500 ns during a burst -> s_axis_tready=0 on the same edge, no further wrn=0 cycles, return to IDLE, bus high-Z.
REQ-026 rxfn=0 with m_axis_tready=1; model drives 0x11, 0x22, 0x33 -> one oen-only cycle, then rdn=0; m_axis outputs 0x11, 0x22, 0x33 with tvalid=1 and no loss.
REQ-027 rxfn and txen low together in IDLE -> READ is entered first; WRITE follows only after READ ends and one IDLE cycle with the bus high-Z.
REQ-028 rstn pulsed low during a write burst -> wrn=1 and bus high-Z immediately (asynchronously); no extra word is written.
